// File: rtl/pwm_audio_out.sv
// Sample FIFO feeding a one-frame-per-sample PWM audio pin; optional first-order
// sigma-delta output when PWM_AUDIO_SIGMA_DELTA_EN is defined. Pin lags the frame counter by 1 clk.
// sample_ready drops only when the FIFO is full (no pop bypass); starved frames repeat duty and pulse underrun.
module pwm_audio_out #(
    parameter int SAMPLE_W    = 4,
    parameter int PRESCALE    = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int START_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          pwm_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] START_L  = LW'(START_LEVEL);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, PLAY, UNDERRUN} state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [PW-1:0]       pre_cnt;
    logic [SAMPLE_W-1:0] pcnt, duty;
    logic                push, pop, tick, boundary, start, empty;

`ifdef PWM_AUDIO_SIGMA_DELTA_EN
    logic [SAMPLE_W:0]   acc, acc_nxt;
    assign acc_nxt = {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, duty};
`endif

    assign sample_ready = !rst && (fifo_level < DEPTH_L);
    assign empty        = (fifo_level == '0);
    assign push         = sample_valid && sample_ready;
    assign tick         = (state != IDLE) && (pre_cnt == PRE_LAST);
    assign boundary     = tick && (pcnt == '1);
    assign start        = (state == IDLE) && enable && (fifo_level >= START_L);
    assign pop          = enable && (start || (boundary && !empty));

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            pcnt     <= '0;
            duty     <= '0;
            pwm_out  <= 1'b0;
            underrun <= 1'b0;
`ifdef PWM_AUDIO_SIGMA_DELTA_EN
            acc      <= '0;
`endif
        end else begin
            underrun <= 1'b0;
            if (!enable) begin
                // FIFO contents survive a disable; only the playback side is cleared
                state   <= IDLE;
                pre_cnt <= '0;
                pcnt    <= '0;
                duty    <= '0;
                pwm_out <= 1'b0;
`ifdef PWM_AUDIO_SIGMA_DELTA_EN
                acc     <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        pre_cnt <= '0;
                        pcnt    <= '0;
                        pwm_out <= 1'b0;
`ifdef PWM_AUDIO_SIGMA_DELTA_EN
                        acc     <= '0;
`endif
                        if (start) begin
                            duty  <= mem[rd_ptr];
                            state <= PLAY;
                        end
                    end
                    default: begin
                        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                        if (tick)
                            pcnt <= pcnt + 1'b1;
                        if (boundary) begin
                            if (!empty) begin
                                duty  <= mem[rd_ptr];
                                state <= PLAY;
                            end else begin
                                underrun <= 1'b1;
                                state    <= UNDERRUN;
                            end
                        end
`ifdef PWM_AUDIO_SIGMA_DELTA_EN
                        if (tick) begin
                            acc     <= acc_nxt;
                            pwm_out <= acc_nxt[SAMPLE_W];
                        end
`else
                        pwm_out <= (pcnt < duty);
`endif
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out at default parameters (4-bit samples, PRESCALE=1, 4-deep FIFO).
module tb_pwm_audio_out;
    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       pwm_out;
    logic       underrun;
    logic [2:0] fifo_level;

    int errs   = 0;
    int checks = 0;

    pwm_audio_out dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Samples pwm_out after each of the next 16 edges; optionally pushes pv on the first edge.
    task automatic run_frame(input int pv, output logic [15:0] pat, output int ur);
        pat = '0;
        ur  = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0 && pv >= 0) begin
                sample_valid = 1'b1;
                sample_in    = pv[3:0];
            end
            step();
            sample_valid = 1'b0;
            pat[k] = pwm_out;
            ur += int'(underrun);
        end
    endtask

    task automatic check_frame(input string tag, input int duty, input int pv,
                               input int exp_ur, input int sd_pat);
        logic [15:0] pat;
        int          ur;
        run_frame(pv, pat, ur);
        chk({tag, "_hi"}, $countones(pat), duty);
        chk({tag, "_ur"}, ur, exp_ur);
`ifdef PWM_AUDIO_SIGMA_DELTA_EN
        if (sd_pat >= 0)
            chk({tag, "_pat"}, {16'd0, pat}, sd_pat);
`else
        chk({tag, "_pat"}, {16'd0, pat}, (32'd1 << duty) - 32'd1);
`endif
    endtask

    initial begin
        int vals [5];
        vals = '{0, 15, 7, 9, 5};

        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 4'd5;
        repeat (3) step();
        chk("rst_ready", sample_ready, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_underrun", underrun, 0);
        rst          = 1'b0;
        sample_valid = 1'b0;
        #1;
        chk("rel_ready", sample_ready, 1);
        chk("rel_level", fifo_level, 0);
        step();
        chk("rel_level2", fifo_level, 0);

        // Prefill 8 then 4; playback starts on the edge after the level reaches 2
        enable       = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 4'd8;
        step();
        sample_in    = 4'd4;
        step();
        sample_valid = 1'b0;
        chk("pre_level", fifo_level, 2);
        chk("pre_pwm", pwm_out, 0);
        step();
        chk("start_pop", fifo_level, 1);
        check_frame("f1_d8", 8, -1, 0, 'hAAAA);
        check_frame("f2_d4", 4, 12, 0, 'h8888);
        check_frame("f3_d12", 12, -1, 1, -1);
        check_frame("f4_hold12", 12, -1, 1, -1);
        check_frame("f5_hold12", 12, 3, 0, -1);
        check_frame("f6_d3", 3, -1, 1, -1);
        enable = 1'b0;
        step();
        chk("dis_pwm", pwm_out, 0);
        chk("dis_level", fifo_level, 0);

        // Fill the FIFO while idle; the fifth sample must be refused
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample_in    = vals[i][3:0];
            #1;
            chk("full_rdy", sample_ready, (i < 4) ? 1 : 0);
            step();
        end
        sample_valid = 1'b0;
        chk("full_level", fifo_level, 4);
        enable = 1'b1;
        step();
        chk("full_start", fifo_level, 3);
        check_frame("x_d0", 0, -1, 0, -1);
        check_frame("x_d15", 15, -1, 0, -1);
        check_frame("x_d7", 7, -1, 0, -1);
        check_frame("x_d9", 9, -1, 1, -1);

        // Drop enable mid-frame with one sample queued
        sample_valid = 1'b1;
        sample_in    = 4'd6;
        step();
        sample_valid = 1'b0;
        repeat (3) step();
`ifndef PWM_AUDIO_SIGMA_DELTA_EN
        chk("mid_pwm", pwm_out, 1);
`endif
        chk("mid_level", fifo_level, 1);
        enable = 1'b0;
        step();
        chk("off_pwm", pwm_out, 0);
        chk("off_level", fifo_level, 1);
        chk("off_underrun", underrun, 0);
        step();
        chk("off_level2", fifo_level, 1);

        // One queued sample is below the start level: stay idle
        enable = 1'b1;
        repeat (20) step();
        chk("lvl1_pwm", pwm_out, 0);
        chk("lvl1_level", fifo_level, 1);
        sample_valid = 1'b1;
        sample_in    = 4'd10;
        step();
        sample_valid = 1'b0;
        chk("lvl2_level", fifo_level, 2);
        step();
        chk("lvl2_start", fifo_level, 1);
        step();
`ifndef PWM_AUDIO_SIGMA_DELTA_EN
        chk("lvl2_pwm", pwm_out, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
- Output stage that consumes the 4-bit audio samples produced by the piano tone generator.
- Buffers incoming samples in a small FIFO using a valid/ready handshake.
- Turns each sample into one fixed-length pulse-width-modulated frame on a 1-bit audio pin, which drives an RC filter and speaker.
- Reports FIFO starvation (underrun) to the tone generator side.

Parameters:
- SAMPLE_W, 4, sample width in bits; one PWM frame is 2^SAMPLE_W ticks.
- PRESCALE, 1, clk cycles per PWM tick; must be >= 1.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2 and >= 2.
- START_LEVEL, 2, FIFO fill level needed to leave IDLE; must be in 1..FIFO_DEPTH.

Ports:
- clk  input  1  system clock (5 MHz on board).
- rst  input  1  reset, synchronous to clk, active-high.
- enable  input  1  playback enable.
- sample_in  input  SAMPLE_W  unsigned sample; 0 = silent, max = loudest.
- sample_valid  input  1  sample_in holds a sample.
- sample_ready  output  1  FIFO can accept a sample.
- pwm_out  output  1  registered audio pin.
- underrun  output  1  one-cycle pulse on a starved frame.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset and clock: one clock domain. rst is synchronous and active-high.
- Values while rst is high and on the first cycle after it:
  - state=IDLE, pwm_out=0, underrun=0, fifo_level=0.
  - FIFO emptied; duty=0; prescale and frame counters=0.
  - sample_ready=0 while rst is high, and 1 on the cycle after rst falls.
- Push:
  - A push happens when sample_valid && sample_ready.
  - sample_ready = (fifo_level < FIFO_DEPTH), decoded from registered state.
  - There is no same-cycle bypass: when full, ready=0 even if a pop happens that cycle.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - Pushes are accepted in every state, including IDLE.
- Tick: asserted for one cycle when the prescale counter reaches PRESCALE-1; the counter then wraps to 0.
- Frame counter: pcnt (SAMPLE_W bits) increments on each tick and wraps from 2^SAMPLE_W-1 to 0.
- Frame boundary: the tick on which pcnt wraps to 0. Duty is only ever loaded at a frame boundary.
- States:
  - IDLE:
    - Prescale counter and pcnt held at 0; pwm_out=0; no pops.
    - Goes to PLAY when enable && fifo_level >= START_LEVEL.
    - On that transition, pop the head into duty in the same cycle; pcnt starts at 0.
  - PLAY: at each frame boundary:
    - FIFO non-empty: pop into duty.
    - FIFO empty: keep the previous duty, pulse underrun for 1 cycle, go to UNDERRUN.
  - UNDERRUN: at each frame boundary:
    - FIFO non-empty: pop into duty, go to PLAY.
    - FIFO empty: keep duty and pulse underrun again.
  - From any state, enable=0 moves to IDLE on the next cycle. FIFO contents are kept; duty is cleared to 0.
- PWM output:
  - pwm_out <= (pcnt < duty), registered, so it lags pcnt by 1 cycle.
  - duty=0 keeps the pin low for the whole frame; duty=15 (SAMPLE_W=4) is high for 15 of 16 ticks.
- Frame length = PRESCALE * 2^SAMPLE_W clk cycles; each sample plays for exactly one frame.
- All arithmetic is unsigned. The level counter never goes above FIFO_DEPTH or below 0.
- Reset in mid-frame overrides everything: values as listed above, and any pending FIFO data is discarded.

Optional Feature:
- Macro: PWM_AUDIO_SIGMA_DELTA_EN.
- With the macro defined:
  - pwm_out comes from a first-order sigma-delta modulator.
  - The accumulator acc is SAMPLE_W+1 bits, reset to 0.
  - On each tick: acc <= {1'b0, acc[SAMPLE_W-1:0]} + duty; pwm_out <= carry bit acc[SAMPLE_W] of the new sum.
  - In IDLE, acc is cleared.
  - Duty loading, FIFO, states and underrun behave as above.
  - Average density per frame equals duty/2^SAMPLE_W, with the high ticks spread across the frame.
- Without the macro: plain PWM as described in Behaviour; the accumulator logic is not present.

Test Plan:
- Reset: hold rst for 3 cycles with sample_valid=1 -> during reset sample_ready=0, pwm_out=0, fifo_level=0; after release sample_ready=1 and the FIFO is empty.
- Prefill and start (PRESCALE=1): enable=1, push 8 then 4 -> PLAY entered once fifo_level=2. Frame 1: pwm_out high for 8 of 16 cycles, starting 1 cycle after the transition. Frame 2: high for 4 of 16.
- Full FIFO: push 5 samples back-to-back while in IDLE -> 4 accepted, ready=0 on the 5th, fifo_level=4; the 5th sample is not stored.
- Underrun: play a single queued sample 12 with no further pushes -> underrun pulses at each following frame boundary and pwm_out keeps 12/16. Pushing 3 returns to PLAY at the next boundary with 3/16.
- Extreme duties: sample 0 -> pwm_out low for the whole frame; sample 15 -> high 15 cycles and low 1 per frame. Drop enable mid-frame -> IDLE next cycle, pwm_out=0, FIFO level kept.
- With PWM_AUDIO_SIGMA_DELTA_EN: sample 4 -> pwm_out high on exactly 4 of 16 ticks, never two in a row; sample 8 -> alternating 1/0 pattern.
